apb_cmd_master: RTL and testbench
=================================

Name: apb_cmd_master

Overview:
- APB requester stage that drives the PSEL/PENABLE/PADDR/PWRITE/PWDATA bus of a single APB completer. It sits directly upstream of the memory-backed wait-state slave.
- It turns a valid/ready command stream from the system side into one APB transfer at a time. It then returns the read data and status on a valid/ready response channel.
- It adds an access-phase timeout and a saturating error counter for debug.

Parameters:
- ADDR_W, 32, width of cmd_addr and PADDR.
- DATA_W, 32, width of write/read data.
- TIMEOUT, 16, maximum ACCESS cycles with PREADY=0 before the transfer is aborted; 0 disables the timeout.

Ports:
- PCLK  input  1  APB clock
- PRESETn  input  1  asynchronous active-low reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  command accepted when high together with cmd_valid
- cmd_write  input  1  1=write, 0=read
- cmd_addr  input  ADDR_W  byte address, forwarded unmodified
- cmd_wdata  input  DATA_W  write data
- rsp_valid  output  1  response available
- rsp_ready  input  1  response consumed
- rsp_rdata  output  DATA_W  read data; 0 for writes and timeouts
- rsp_slverr  output  1  PSLVERR captured at completion
- rsp_timeout  output  1  transfer aborted by timeout
- err_count  output  8  saturating count of responses with rsp_slverr or rsp_timeout set
- PSEL  output  1  APB select
- PENABLE  output  1  APB enable
- PWRITE  output  1  APB direction
- PADDR  output  ADDR_W  APB address
- PWDATA  output  DATA_W  APB write data
- PRDATA  input  DATA_W  APB read data
- PREADY  input  1  APB ready
- PSLVERR  input  1  APB error

Behaviour:
- Reset is PRESETn, asynchronous, active-low; the clock is PCLK. All flops reset asynchronously.
- Reset values: state=IDLE; PSEL, PENABLE and PWRITE are 0; PADDR and PWDATA are 0; rsp_valid, rsp_slverr and rsp_timeout are 0; rsp_rdata is 0; err_count is 0; wait counter is 0.
- cmd_ready = (state==IDLE), combinational. No other output is combinational.
- FSM state IDLE:
  - On cmd_valid&&cmd_ready, register cmd_addr to PADDR, cmd_wdata to PWDATA and cmd_write to PWRITE.
  - In the same edge set PSEL<=1 and PENABLE<=0, then go to SETUP.
  - With no command, PSEL and PENABLE stay 0.
- FSM state SETUP: lasts exactly 1 cycle. Set PENABLE<=1, clear the wait counter, go to ACCESS.
- FSM state ACCESS, PREADY=1 sampled:
  - Set PSEL<=0 and PENABLE<=0.
  - rsp_rdata <= PWRITE ? 0 : PRDATA.
  - rsp_slverr <= PSLVERR; rsp_timeout <= 0; rsp_valid <= 1; go to RESP.
- FSM state ACCESS, PREADY=0 sampled:
  - Increment the wait counter.
  - If TIMEOUT!=0 and the counter equals TIMEOUT-1, abort instead: PSEL<=0, PENABLE<=0, rsp_rdata<=0, rsp_slverr<=0, rsp_timeout<=1, rsp_valid<=1, go to RESP.
- FSM state RESP:
  - Hold all rsp_* stable until rsp_ready.
  - On rsp_valid&&rsp_ready, set rsp_valid<=0 and go to IDLE.
  - err_count increments on the RESP entry edge if the error/timeout bit is set, saturating at 255.
- Bus stability: PADDR, PWRITE and PWDATA hold from the acceptance edge until the next acceptance. They do not change during SETUP or ACCESS.
- Bus idle spacing: at least one cycle with PSEL=0 separates consecutive transfers, because of the RESP handshake plus the IDLE acceptance cycle. Minimum command-to-command spacing is 4 cycles when rsp_ready is held high.
- Wait-counter width is clog2(TIMEOUT+1), minimum 1 bit, with no wrap before the compare.
- PADDR[1:0] is passed through unmodified; no alignment masking is done.
- Simultaneous events:
  - A PREADY=1 on the timeout cycle completes normally; PREADY takes priority over timeout.
  - cmd_valid during RESP or any non-IDLE state is not accepted, and the command must be held by the source.
- Reset mid-operation:
  - The FSM returns to IDLE immediately and the bus drops to PSEL=0 and PENABLE=0.
  - The in-flight command is lost and no response is produced.
  - err_count clears.
- PRDATA and PSLVERR are ignored except on the ACCESS cycle where PREADY=1.

Test Plan:
- Write, 0 waits: cmd write addr 0x0000_0010, data 0xDEAD_BEEF. Required:
  - PSEL rises 1 cycle after acceptance, PENABLE 1 cycle later.
  - PWDATA equals 0xDEAD_BEEF throughout.
  - rsp_valid with rsp_rdata=0, slverr=0, timeout=0.
- Read with wait states: read addr 0x0000_0013, completer PREADY after 4 ACCESS cycles, PRDATA=0x1234_5678. Required:
  - PENABLE is high for 4 cycles.
  - rsp_rdata=0x1234_5678.
  - PADDR=0x13 stable through the transfer.
- Slave error: read addr 0x0000_1000 returning PSLVERR=1 with PREADY. Required: rsp_slverr=1 and err_count 0->1.
- Timeout, TIMEOUT=16: PREADY held 0. Required:
  - Abort after 16 ACCESS cycles with PSEL and PENABLE low.
  - rsp_timeout=1 and rsp_rdata=0.
  - PREADY=1 exactly on cycle 16 completes normally instead.
- Backpressure and back-to-back: rsp_ready low for 5 cycles with cmd_valid held. Required:
  - cmd_ready=0 until the response is taken.
  - The second transfer starts only after IDLE, with PSEL low for at least 1 cycle between transfers.
- Reset mid-ACCESS: assert PRESETn low during PENABLE=1. Required:
  - PSEL, PENABLE and rsp_valid go to 0 immediately.
  - cmd_ready=1 after release.
  - No response is emitted.

Source files
------------

// File: rtl/apb_cmd_master.sv
// APB requester: accepts one valid/ready command at a time, runs a single APB
// transfer with an access-phase timeout, and returns status on a response channel.
module apb_cmd_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_slverr,
    output logic              rsp_timeout,
    output logic [7:0]        err_count,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    // state  | meaning
    // IDLE   | waiting for a command, cmd_ready high
    // SETUP  | PSEL=1, PENABLE=0 for one cycle
    // ACCESS | PENABLE=1, waiting for PREADY or timeout
    // RESP   | response held until rsp_ready

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    assign cmd_ready = (state == IDLE);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= IDLE;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b0;
            rsp_timeout <= 1'b0;
            err_count   <= 8'd0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        PADDR   <= cmd_addr;
                        PWDATA  <= cmd_wdata;
                        PWRITE  <= cmd_write;
                        PSEL    <= 1'b1;
                        PENABLE <= 1'b0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    // PREADY wins over a timeout landing on the same cycle
                    if (PREADY) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_rdata   <= PWRITE ? '0 : PRDATA;
                        rsp_slverr  <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        if (PSLVERR && err_count != 8'hFF)
                            err_count <= err_count + 8'd1;
                        state <= RESP;
                    end else if (TIMEOUT != 0 && wait_cnt == TO_LAST) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_rdata   <= '0;
                        rsp_slverr  <= 1'b0;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        if (err_count != 8'hFF)
                            err_count <= err_count + 8'd1;
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: a scripted/random APB completer plus a transfer-level
// reference model (wait count -> enable cycles, response fields, error count).
module tb_apb_cmd_master;

    localparam int TIMEOUT = 16;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr, rsp_timeout;
    logic [7:0]  err_count;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PREADY, PSLVERR;

    int checks = 0;
    int passed = 0;
    int exp_err = 0;

    always #5 PCLK = ~PCLK;

    apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout), .err_count(err_count),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // One full command/response transaction. waits = PREADY=0 cycles the completer
    // inserts before PREADY=1. With hold_next, the next command is presented while
    // the response is pending and left asserted for the following call.
    task automatic do_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input bit slv, input int waits,
                           input int rsp_delay, input bit hold_next, input bit nwr,
                           input logic [31:0] naddr, input logic [31:0] nwdata);
        bit          exp_to;
        int          exp_n, n;
        logic [31:0] exp_rd;
        bit          exp_se;
        exp_to = (TIMEOUT != 0) && (waits >= TIMEOUT);
        exp_n  = exp_to ? TIMEOUT : waits + 1;
        exp_rd = (exp_to || wr) ? 32'd0 : rdata;
        exp_se = exp_to ? 1'b0 : slv;
        if ((exp_se || exp_to) && exp_err < 255) exp_err++;

        checks++;
        if (cmd_ready !== 1'b1 || PSEL !== 1'b0) $display("FAIL idle_before_cmd cmd_ready=%b PSEL=%b want 1/0", cmd_ready, PSEL);
        else passed++;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        tick();
        cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_write = $urandom_range(0, 1);
        checks++;
        if (PSEL !== 1'b1 || PENABLE !== 1'b0 || cmd_ready !== 1'b0)
            $display("FAIL setup_phase PSEL=%b PENABLE=%b cmd_ready=%b want 1/0/0", PSEL, PENABLE, cmd_ready);
        else passed++;
        checks++;
        if (PADDR !== addr || PWDATA !== wdata || PWRITE !== wr)
            $display("FAIL setup_bus PADDR=%h PWDATA=%h PWRITE=%b want %h/%h/%b", PADDR, PWDATA, PWRITE, addr, wdata, wr);
        else passed++;
        tick();
        n = 0;
        while (PENABLE === 1'b1 && n < 64) begin
            n++;
            checks++;
            if (PSEL !== 1'b1 || PADDR !== addr || PWDATA !== wdata || PWRITE !== wr || rsp_valid !== 1'b0)
                $display("FAIL access_stable cyc=%0d PSEL=%b PADDR=%h PWDATA=%h rsp_valid=%b want 1/%h/%h/0", n, PSEL, PADDR, PWDATA, rsp_valid, addr, wdata);
            else passed++;
            PREADY  = (n == waits + 1);
            PRDATA  = PREADY ? rdata : $urandom;
            PSLVERR = PREADY ? slv : 1'($urandom_range(0, 1));
            tick();
            PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = $urandom;
        end
        checks++;
        if (n !== exp_n) $display("FAIL enable_cycles got=%0d want=%0d", n, exp_n);
        else passed++;
        checks++;
        if (PSEL !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== exp_rd || rsp_slverr !== exp_se || rsp_timeout !== exp_to)
            $display("FAIL response PSEL=%b v=%b rdata=%h se=%b to=%b want 0/1/%h/%b/%b", PSEL, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout, exp_rd, exp_se, exp_to);
        else passed++;
        checks++;
        if (err_count !== 8'(exp_err)) $display("FAIL err_count got=%0d want=%0d", err_count, exp_err);
        else passed++;
        if (hold_next) begin
            cmd_valid = 1'b1; cmd_write = nwr; cmd_addr = naddr; cmd_wdata = nwdata;
        end
        for (int d = 0; d < rsp_delay; d++) begin
            checks++;
            if (cmd_ready !== 1'b0 || PSEL !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== exp_rd ||
                rsp_slverr !== exp_se || rsp_timeout !== exp_to || PADDR !== addr)
                $display("FAIL rsp_hold d=%0d cmd_ready=%b PSEL=%b v=%b rdata=%h PADDR=%h want 0/0/1/%h/%h", d, cmd_ready, PSEL, rsp_valid, rsp_rdata, PADDR, exp_rd, addr);
            else passed++;
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || PSEL !== 1'b0)
            $display("FAIL rsp_taken rsp_valid=%b cmd_ready=%b PSEL=%b want 0/1/0", rsp_valid, cmd_ready, PSEL);
        else passed++;
    endtask

    task automatic test_reset();
        PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        #12;
        checks++;
        if (PSEL !== 1'b0 || PENABLE !== 1'b0 || PWRITE !== 1'b0 || PADDR !== 32'd0 || PWDATA !== 32'd0 ||
            rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_slverr !== 1'b0 || rsp_timeout !== 1'b0 ||
            err_count !== 8'd0 || cmd_ready !== 1'b1)
            $display("FAIL reset_values PSEL=%b PEN=%b PADDR=%h v=%b err=%0d cmd_ready=%b", PSEL, PENABLE, PADDR, rsp_valid, err_count, cmd_ready);
        else passed++;
        @(negedge PCLK);
        PRESETn = 1'b1;
        tick();
        exp_err = 0;
    endtask

    task automatic test_write_0wait();
        do_xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, 0, 0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_read_waits();
        do_xfer(1'b0, 32'h0000_0013, 32'h0, 32'h1234_5678, 1'b0, 3, 1, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_slverr();
        do_xfer(1'b0, 32'h0000_1000, 32'h0, 32'hA5A5_A5A5, 1'b1, 0, 0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_timeout();
        do_xfer(1'b0, 32'h0000_2000, 32'h0, 32'h1111_2222, 1'b0, TIMEOUT, 0, 1'b0, 1'b0, '0, '0);
        do_xfer(1'b0, 32'h0000_2004, 32'h0, 32'h3333_4444, 1'b0, TIMEOUT - 1, 0, 1'b0, 1'b0, '0, '0);
        do_xfer(1'b1, 32'h0000_2008, 32'h5555_6666, 32'h0, 1'b0, TIMEOUT + 3, 0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_back_to_back();
        do_xfer(1'b1, 32'h0000_0100, 32'h0BAD_CAFE, 32'h0, 1'b0, 1, 5, 1'b1, 1'b0, 32'h0000_0105, 32'h0);
        do_xfer(1'b0, 32'h0000_0105, 32'h0, 32'h7777_8888, 1'b0, 0, 0, 1'b1, 1'b1, 32'h0000_0106, 32'h99);
        do_xfer(1'b1, 32'h0000_0106, 32'h99, 32'h0, 1'b1, 2, 2, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            do_xfer(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, ($urandom_range(0, 3) == 0),
                    int'($urandom_range(0, TIMEOUT + 4)), int'($urandom_range(0, 3)), 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_err_saturate();
        while (exp_err < 255)
            do_xfer(1'b0, $urandom, 32'h0, $urandom, 1'b1, 0, 0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 3; i++)
            do_xfer(1'b0, $urandom, 32'h0, $urandom, 1'b1, 0, 0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_reset_mid_access();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_3000; cmd_wdata = 32'h1357_9BDF;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (PENABLE !== 1'b1 || PSEL !== 1'b1) $display("FAIL pre_reset_access PSEL=%b PENABLE=%b want 1/1", PSEL, PENABLE);
        else passed++;
        PRESETn = 1'b0;
        #1;
        exp_err = 0;
        checks++;
        if (PSEL !== 1'b0 || PENABLE !== 1'b0 || rsp_valid !== 1'b0 || err_count !== 8'd0)
            $display("FAIL reset_mid PSEL=%b PENABLE=%b rsp_valid=%b err=%0d want 0/0/0/0", PSEL, PENABLE, rsp_valid, err_count);
        else passed++;
        @(negedge PCLK);
        PRESETn = 1'b1;
        PREADY = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || PSEL !== 1'b0)
                $display("FAIL post_reset c=%0d cmd_ready=%b rsp_valid=%b PSEL=%b want 1/0/0", i, cmd_ready, rsp_valid, PSEL);
            else passed++;
        end
        PREADY = 1'b0;
        do_xfer(1'b0, 32'h0000_3004, 32'h0, 32'h2468_ACE0, 1'b0, 1, 0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        test_reset();
        test_write_0wait();
        test_read_waits();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_random();
        test_err_saturate();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
